button_reader: RTL and testbench
================================

Name: button_reader

Overview:
Input-side counterpart to the board's LED drivers. It samples one raw, bouncing push-button or switch pin and synchronises it into the CLK domain. It debounces the signal and produces a clean level, single-cycle press/release strobes and a wrapping press counter. It sits directly behind a top-level input pad and feeds user logic such as LED mode selection.

Parameters:
DEBOUNCE_CYCLES, 120000, number of consecutive stable cycles needed to accept a level change (10 ms at 12 MHz); legal minimum is 2.
LONG_CYCLES, 12000000, cycles held after acceptance before the long-press strobe fires (1 s at 12 MHz); legal minimum is 2; used only with the optional feature.
CNT_W, 8, width of the press counter.
ACTIVE_LOW, 1, 1 means the pin reads 0 when pressed (pull-up); 0 means the pin reads 1 when pressed.

Ports:
CLK  in  1  system clock. Single clock domain.
RST_N  in  1  reset. Synchronous, active-low.
BTN  in  1  raw pin. Asynchronous to CLK and may bounce.
PRESSED  out  1  debounced level. 1 while the button is accepted as held.
PRESS  out  1  one-cycle strobe when a press is accepted.
RELEASE  out  1  one-cycle strobe when a release is accepted.
LONG  out  1  one-cycle strobe for a long press (optional feature).
COUNT  out  CNT_W  number of accepted presses, modulo 2^CNT_W.

Behaviour:
- Reset: applied on a CLK rising edge while RST_N=0. PRESSED, PRESS, RELEASE, LONG and COUNT all go to 0. FSM goes to RELEASED. Debounce and hold counters go to 0. Both synchroniser flops load the inactive pin level (ACTIVE_LOW ? 1 : 0), so exiting reset can never produce a spurious press.
- Synchroniser: two flops on BTN, with no logic between them. act = second flop XOR ACTIVE_LOW, so act=1 means pressed.
- FSM, with dcnt as the debounce counter (width ceil(log2(DEBOUNCE_CYCLES))):
  RELEASED: if act=1, go to ARM_PRESS and set dcnt<=0.
  ARM_PRESS: if act=0, return to RELEASED; this is a glitch and produces no output. Else if dcnt==DEBOUNCE_CYCLES-1, go to HELD and set PRESSED<=1, PRESS<=1, COUNT<=COUNT+1. Else dcnt<=dcnt+1.
  HELD: if act=0, go to ARM_RELEASE and set dcnt<=0.
  ARM_RELEASE: if act=1, return to HELD; PRESSED stays 1 and no strobe fires. Else if dcnt==DEBOUNCE_CYCLES-1, go to RELEASED and set PRESSED<=0, RELEASE<=1. Else dcnt<=dcnt+1.
- Strobes: PRESS, RELEASE and LONG are registered. Each is high for exactly one cycle and 0 in every other cycle.
- Latency: call the first CLK edge that samples BTN active edge 0. With BTN stable from then on, PRESSED and PRESS go high on edge DEBOUNCE_CYCLES+2. Release has the same latency, from the first edge that samples BTN inactive to RELEASE.
- Bounce: any reversal of act before dcnt completes restarts acceptance from scratch. Accepted edges therefore always alternate press, release, press, and so on.
- COUNT: wraps from 2^CNT_W-1 to 0 with no flag. It changes only on the PRESS cycle.
- Reset mid-operation: applies all reset values, including dropping PRESSED immediately, and emits no RELEASE. If the button is still held after reset, a new press is accepted after the full latency.

Optional Feature:
Macro: BUTTON_LONG_PRESS_EN.
- Defined: a hold counter is cleared to 0 on entry to HELD from ARM_PRESS. It increments each cycle in HELD, is frozen in ARM_RELEASE, and is not cleared by a bounce back to HELD.
  - When it equals LONG_CYCLES-1 in HELD, LONG<=1 for one cycle and the counter saturates there.
  - At most one LONG per press. With steady hold, LONG is exactly LONG_CYCLES edges after the PRESS edge.
  - Reset clears the hold counter.
- Undefined: no hold counter is instantiated. LONG is tied to 0 and the port is still present.

Test Plan:
Use DEBOUNCE_CYCLES=4, LONG_CYCLES=16, CNT_W=4, ACTIVE_LOW=1 for all scenarios.
1. Reset with BTN=1, release RST_N, idle 20 cycles -> all outputs 0 and no strobe.
2. Drive BTN 1->0 and hold -> PRESS high only on edge 6 after the first sampling edge; PRESSED=1 from edge 6; COUNT=1.
3. From HELD, drive BTN=1 for 3 cycles then 0 -> no RELEASE and PRESSED stays 1. Then hold BTN=1 -> RELEASE pulse on edge 6 after sampling; PRESSED=0.
4. From RELEASED, pulse BTN low for 1, 2 and 3 cycles separated by high gaps -> no PRESS and COUNT unchanged. Follow with a 20-cycle low -> exactly one PRESS.
5. Perform 17 clean press/release pairs -> COUNT reads 1 after the 17th PRESS (wrap at 16).
6. Hold 40 cycles past PRESS -> with BUTTON_LONG_PRESS_EN, exactly one LONG on edge 16 after PRESS; without it, LONG=0 throughout. Assert RST_N=0 mid-hold with BTN still low -> PRESSED=0 and no RELEASE; after release of reset, PRESS again 6 edges after the first active sample.

Source files
------------

// File: rtl/button_reader.sv
// Debounced push-button reader: 2-flop synchroniser, press/release FSM,
// strobes and wrapping press counter. Optional long press: BUTTON_LONG_PRESS_EN.
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int CNT_W           = 8,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             BTN,
    output logic             PRESSED,
    output logic             PRESS,
    output logic             RELEASE,
    output logic             LONG,
    output logic [CNT_W-1:0] COUNT
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        ARM_PRESS,
        HELD,
        ARM_RELEASE
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             act;
    state_t           state_q;
    state_t           state_d;
    logic [DW-1:0]    dcnt_q;
    logic [DW-1:0]    dcnt_d;
    logic             pressed_d;
    logic             press_d;
    logic             release_d;
    logic [CNT_W-1:0] count_d;

    // Two-flop synchroniser, reset to the idle pin level
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= BTN;
            sync2_q <= sync1_q;
        end
    end

    assign act = sync2_q ^ IDLE_LVL;

    // State, debounce counter and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= RELEASED;
            dcnt_q  <= '0;
            PRESSED <= 1'b0;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            COUNT   <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            PRESSED <= pressed_d;
            PRESS   <= press_d;
            RELEASE <= release_d;
            COUNT   <= count_d;
        end
    end

    // Next-state logic: every reversal of act restarts acceptance
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        pressed_d = PRESSED;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = COUNT;
        unique case (state_q)
            RELEASED: begin
                if (act) begin
                    state_d = ARM_PRESS;
                    dcnt_d  = '0;
                end
            end
            ARM_PRESS: begin
                if (!act) begin
                    state_d = RELEASED;
                end else if (dcnt_q == DLAST) begin
                    state_d   = HELD;
                    pressed_d = 1'b1;
                    press_d   = 1'b1;
                    count_d   = COUNT + CNT_W'(1);
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            HELD: begin
                if (!act) begin
                    state_d = ARM_RELEASE;
                    dcnt_d  = '0;
                end
            end
            ARM_RELEASE: begin
                if (act) begin
                    state_d = HELD;
                end else if (dcnt_q == DLAST) begin
                    state_d   = RELEASED;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [HW-1:0] HLAST = HW'(LONG_CYCLES - 1);

    logic          enter_held;
    logic [HW-1:0] hcnt_q;
    logic          ldone_q;

    assign enter_held = (state_q == ARM_PRESS) && (state_d == HELD);

    // Hold timer: runs in HELD, frozen while arming a release, one LONG per press
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hcnt_q  <= '0;
            ldone_q <= 1'b0;
            LONG    <= 1'b0;
        end else if (enter_held) begin
            hcnt_q  <= '0;
            ldone_q <= 1'b0;
            LONG    <= 1'b0;
        end else if (state_q == HELD) begin
            LONG <= 1'b0;
            if (hcnt_q == HLAST) begin
                if (!ldone_q) begin
                    LONG    <= 1'b1;
                    ldone_q <= 1'b1;
                end
            end else begin
                hcnt_q <= hcnt_q + HW'(1);
            end
        end else begin
            LONG <= 1'b0;
        end
    end
`else
    assign LONG = 1'b0;
`endif

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: edge-level acceptance model plus directed
// scenarios with hand-computed latencies and counts.
module tb_button_reader;

    localparam int D = 4;
    localparam int L = 16;
    localparam int W = 4;

    logic         CLK;
    logic         RST_N;
    logic         BTN;
    logic         PRESSED;
    logic         PRESS;
    logic         RELEASE;
    logic         LONG;
    logic [W-1:0] COUNT;

    int checks   = 0;
    int failures = 0;

    button_reader #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .CNT_W(W),
        .ACTIVE_LOW(1)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .BTN(BTN),
        .PRESSED(PRESSED),
        .PRESS(PRESS),
        .RELEASE(RELEASE),
        .LONG(LONG),
        .COUNT(COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the FSM sees each pin sample two edges late; a level is
    // accepted after D+1 consecutive opposite samples.
    bit m_p1 = 1'b1;
    bit m_p2 = 1'b1;
    bit m_acc = 1'b0;
    int m_run = 0;
    int m_count = 0;
    bit m_press = 1'b0;
    bit m_rel = 1'b0;
    bit m_long = 1'b0;
    int m_h = 0;
    bit m_done = 1'b0;
    bit started = 1'b0;
    int cyc = 0;

    always @(posedge CLK) begin
        bit a;
        cyc++;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (!RST_N) begin
            m_p1 = 1'b1;
            m_p2 = 1'b1;
            m_acc = 1'b0;
            m_run = 0;
            m_count = 0;
            m_h = 0;
            m_done = 1'b0;
        end else begin
            a = ~m_p2;
            m_p2 = m_p1;
            m_p1 = BTN;
            if (m_acc && m_run == 0) begin
                if (m_h == L - 1) begin
                    if (!m_done) begin
                        m_long = 1'b1;
                        m_done = 1'b1;
                    end
                end else begin
                    m_h++;
                end
            end
            if (a != m_acc) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_acc = a;
                    m_run = 0;
                    if (a) begin
                        m_press = 1'b1;
                        m_count = (m_count + 1) % (1 << W);
                        m_h = 0;
                        m_done = 1'b0;
                    end else begin
                        m_rel = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
        started = 1'b1;
    end

    int n_press = 0;
    int n_rel = 0;
    int n_long = 0;
    int press_cyc = 0;
    int long_cyc = 0;

    // Compare every cycle and tally strobes
    always @(negedge CLK) begin
        int exp_long;
        if (started) begin
`ifdef BUTTON_LONG_PRESS_EN
            exp_long = int'(m_long);
`else
            exp_long = 0;
`endif
            chk("pressed", int'(PRESSED), int'(m_acc));
            chk("press", int'(PRESS), int'(m_press));
            chk("release", int'(RELEASE), int'(m_rel));
            chk("long", int'(LONG), exp_long);
            chk("count", int'(COUNT), m_count);
            if (PRESS === 1'b1) begin
                n_press++;
                press_cyc = cyc;
            end
            if (RELEASE === 1'b1) n_rel++;
            if (LONG === 1'b1) begin
                n_long++;
                long_cyc = cyc;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drive at a negedge: the next posedge is edge 0
    task automatic drive(input bit v);
        @(negedge CLK);
        BTN = v;
    endtask

    // Returns edge index of the strobe, -1 on timeout
    task automatic wait_strobe(input bit rel, output int n);
        n = -1;
        for (int k = 0; k < 50; k++) begin
            @(posedge CLK);
            #1;
            if ((rel ? RELEASE : PRESS) === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int p0;
        int r0;
        int l0;
        RST_N = 1'b0;
        BTN = 1'b1;
        cycles(3);

        // 1: idle after reset
        RST_N = 1'b1;
        cycles(20);
        chk("idle_strobes", n_press + n_rel + n_long, 0);
        chk("idle_pressed", int'(PRESSED), 0);
        chk("idle_count", int'(COUNT), 0);

        // 2: clean press
        drive(1'b0);
        wait_strobe(1'b0, n);
        chk("press_latency", n, 6);
        #1;
        chk("press_level", int'(PRESSED), 1);
        chk("press_count", int'(COUNT), 1);
        cycles(5);

        // 3: short release bounce, then real release
        r0 = n_rel;
        drive(1'b1);
        cycles(3);
        BTN = 1'b0;
        cycles(10);
        chk("bounce_norel", n_rel - r0, 0);
        chk("bounce_level", int'(PRESSED), 1);
        drive(1'b1);
        wait_strobe(1'b1, n);
        chk("release_latency", n, 6);
        #1;
        chk("release_level", int'(PRESSED), 0);
        cycles(5);

        // 4: glitches of 1..3 cycles, then a real press
        p0 = n_press;
        for (int w = 1; w <= 3; w++) begin
            BTN = 1'b0;
            cycles(w);
            BTN = 1'b1;
            cycles(6);
        end
        chk("glitch_nopress", n_press - p0, 0);
        chk("glitch_count", int'(COUNT), 1);
        BTN = 1'b0;
        cycles(20);
        chk("long_low_press", n_press - p0, 1);
        chk("long_low_count", int'(COUNT), 2);
        BTN = 1'b1;
        cycles(12);

        // 5: 17 presses from zero wrap a 4-bit counter to 1
        RST_N = 1'b0;
        cycles(2);
        RST_N = 1'b1;
        cycles(2);
        p0 = n_press;
        for (int i = 0; i < 17; i++) begin
            BTN = 1'b0;
            cycles(8);
            BTN = 1'b1;
            cycles(8);
        end
        chk("wrap_presses", n_press - p0, 17);
        chk("wrap_count", int'(COUNT), 1);

        // 6: long hold, then reset mid-hold
        l0 = n_long;
        drive(1'b0);
        wait_strobe(1'b0, n);
        chk("hold_press_latency", n, 6);
        cycles(40);
`ifdef BUTTON_LONG_PRESS_EN
        chk("long_once", n_long - l0, 1);
        chk("long_edge", long_cyc - press_cyc, L);
`else
        chk("long_none", n_long - l0, 0);
`endif
        r0 = n_rel;
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_pressed", int'(PRESSED), 0);
        chk("rst_count", int'(COUNT), 0);
        cycles(2);
        chk("rst_norel", n_rel - r0, 0);
        RST_N = 1'b1;
        wait_strobe(1'b0, n);
        chk("rst_repress", n, 6);
        cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
